// File: rtl/rf_wb_bank_scheduler.sv
// Write-back scheduler for a 2-bank (even/odd) 4R2W register file.
// Up to two write-back requests per cycle are steered to their bank by addr[0].
// A request is written the same cycle when its bank has no backlog. Same-bank
// collisions are queued in a per-bank FIFO that drains one entry per cycle.
// Reads that hit a queued, not-yet-written register are flagged busy. After
// reset, write-backs are held off for INIT_CYCLES cycles.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   wb{0,1}_valid_i/addr_i/data_i   write-back requests (wb0 older than wb1)
//   wb_ready_o                      shared ready, taken from registered state only
//   ra_i / rd_busy_o                four read addresses / their RAW-hazard flags
//   rf_we{0,1}_o/wa/wd              even-bank and odd-bank write ports
//   init_busy_o                     high during reset and the init window
module rf_wb_bank_scheduler #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned INIT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb0_valid_i,
  input  logic [4:0]           wb0_addr_i,
  input  logic [WIDTH-1:0]     wb0_data_i,
  input  logic                 wb1_valid_i,
  input  logic [4:0]           wb1_addr_i,
  input  logic [WIDTH-1:0]     wb1_data_i,
  output logic                 wb_ready_o,
  input  logic [3:0][4:0]      ra_i,
  output logic [3:0]           rd_busy_o,
  output logic                 rf_we0_o,
  output logic [4:0]           rf_wa0_o,
  output logic [WIDTH-1:0]     rf_wd0_o,
  output logic                 rf_we1_o,
  output logic [4:0]           rf_wa1_o,
  output logic [WIDTH-1:0]     rf_wd1_o,
  output logic                 init_busy_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(INIT_CYCLES + 1);

  typedef enum logic {StInit, StRun} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      init_cnt_q, init_cnt_d;

  // Per-bank FIFO storage and pointers; index 0 = even bank, 1 = odd bank.
  logic [4:0]         fa_q [2][DEPTH];
  logic [WIDTH-1:0]   fd_q [2][DEPTH];
  logic [AW-1:0]      wp_q [2];
  logic [AW-1:0]      rp_q [2];
  logic [AW:0]        cnt_q [2];

  logic               fire0, fire1;
  logic [1:0]         we_b, pop_b;
  logic [1:0][4:0]    wa_b;
  logic [1:0][WIDTH-1:0] wd_b;
  logic [1:0][1:0]    push_n;
  logic [1:0][1:0][4:0]       pa;
  logic [1:0][1:0][WIDTH-1:0] pd;

  // Init sequencer
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == StInit) begin
      if (init_cnt_q == CW'(INIT_CYCLES - 1)) begin
        state_d = StRun;
      end else begin
        init_cnt_d = init_cnt_q + CW'(1);
      end
    end
  end

  assign init_busy_o = !rst_n || (state_q == StInit);

  // Two-deep headroom per bank guarantees any fire pattern fits without overflow.
  assign wb_ready_o = rst_n && (state_q == StRun) &&
                      (cnt_q[0] <= (AW+1)'(DEPTH - 2)) &&
                      (cnt_q[1] <= (AW+1)'(DEPTH - 2));

  // Requests to r0 are accepted but never written or queued.
  assign fire0 = wb0_valid_i && wb_ready_o && (wb0_addr_i != 5'd0);
  assign fire1 = wb1_valid_i && wb_ready_o && (wb1_addr_i != 5'd0);

  // Per-bank steering: head first, then wb0, then wb1.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      logic r0, r1;
      r0 = fire0 && (wb0_addr_i[0] == 1'(b));
      r1 = fire1 && (wb1_addr_i[0] == 1'(b));
      we_b[b]   = 1'b0;
      wa_b[b]   = '0;
      wd_b[b]   = '0;
      pop_b[b]  = 1'b0;
      push_n[b] = 2'd0;
      pa[b]     = '0;
      pd[b]     = '0;
      if (rst_n && (cnt_q[b] != '0)) begin
        we_b[b]  = 1'b1;
        wa_b[b]  = fa_q[b][rp_q[b]];
        wd_b[b]  = fd_q[b][rp_q[b]];
        pop_b[b] = 1'b1;
        if (r0) begin
          pa[b][0] = wb0_addr_i;
          pd[b][0] = wb0_data_i;
          if (r1) begin
            pa[b][1]  = wb1_addr_i;
            pd[b][1]  = wb1_data_i;
            push_n[b] = 2'd2;
          end else begin
            push_n[b] = 2'd1;
          end
        end else if (r1) begin
          pa[b][0]  = wb1_addr_i;
          pd[b][0]  = wb1_data_i;
          push_n[b] = 2'd1;
        end
      end else if (r0) begin
        we_b[b] = 1'b1;
        wa_b[b] = wb0_addr_i;
        wd_b[b] = wb0_data_i;
        if (r1) begin
          pa[b][0]  = wb1_addr_i;
          pd[b][0]  = wb1_data_i;
          push_n[b] = 2'd1;
        end
      end else if (r1) begin
        we_b[b] = 1'b1;
        wa_b[b] = wb1_addr_i;
        wd_b[b] = wb1_data_i;
      end
    end
  end

  assign rf_we0_o = we_b[0];
  assign rf_wa0_o = wa_b[0];
  assign rf_wd0_o = wd_b[0];
  assign rf_we1_o = we_b[1];
  assign rf_wa1_o = wa_b[1];
  assign rf_wd1_o = wd_b[1];

  // RAW hazard: any live FIFO entry (head included) in the read address's bank.
  always_comb begin
    rd_busy_o = '0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rst_n && (ra_i[k] != 5'd0) &&
            ({1'b0, AW'(AW'(i) - rp_q[ra_i[k][0]])} < cnt_q[ra_i[k][0]]) &&
            (fa_q[ra_i[k][0]][i] == ra_i[k])) begin
          rd_busy_o[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      for (int b = 0; b < 2; b++) begin
        wp_q[b]  <= '0;
        rp_q[b]  <= '0;
        cnt_q[b] <= '0;
      end
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      for (int b = 0; b < 2; b++) begin
        if (push_n[b] != 2'd0) begin
          fa_q[b][wp_q[b]] <= pa[b][0];
          fd_q[b][wp_q[b]] <= pd[b][0];
        end
        if (push_n[b] == 2'd2) begin
          fa_q[b][wp_q[b] + AW'(1)] <= pa[b][1];
          fd_q[b][wp_q[b] + AW'(1)] <= pd[b][1];
        end
        wp_q[b]  <= wp_q[b] + AW'(push_n[b]);
        rp_q[b]  <= rp_q[b] + AW'(pop_b[b]);
        cnt_q[b] <= cnt_q[b] + (AW+1)'(push_n[b]) - (AW+1)'(pop_b[b]);
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_bank_scheduler.sv
// Bench for rf_wb_bank_scheduler. The reference model keeps one queue of pending
// writes per bank: fired requests are appended in program order and every cycle
// the front of a non-empty queue is the expected write. A negedge monitor pops
// and compares against the DUT's write ports, ready, init and hazard outputs.
module tb_rf_wb_bank_scheduler;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int IC = 16;

  logic           clk;
  logic           rst_n;
  logic           wb0_valid_i, wb1_valid_i;
  logic [4:0]     wb0_addr_i, wb1_addr_i;
  logic [W-1:0]   wb0_data_i, wb1_data_i;
  logic           wb_ready_o;
  logic [3:0][4:0] ra_i;
  logic [3:0]     rd_busy_o;
  logic           rf_we0_o, rf_we1_o;
  logic [4:0]     rf_wa0_o, rf_wa1_o;
  logic [W-1:0]   rf_wd0_o, rf_wd1_o;
  logic           init_busy_o;

  rf_wb_bank_scheduler #(.WIDTH(W), .DEPTH(D), .INIT_CYCLES(IC)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb0_valid_i(wb0_valid_i), .wb0_addr_i(wb0_addr_i), .wb0_data_i(wb0_data_i),
    .wb1_valid_i(wb1_valid_i), .wb1_addr_i(wb1_addr_i), .wb1_data_i(wb1_data_i),
    .wb_ready_o(wb_ready_o), .ra_i(ra_i), .rd_busy_o(rd_busy_o),
    .rf_we0_o(rf_we0_o), .rf_wa0_o(rf_wa0_o), .rf_wd0_o(rf_wd0_o),
    .rf_we1_o(rf_we1_o), .rf_wa1_o(rf_wa1_o), .rf_wd1_o(rf_wd1_o),
    .init_busy_o(init_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]   a;
    logic [W-1:0] d;
  } ent_t;

  ent_t         mq0[$];
  ent_t         mq1[$];
  logic [W-1:0] model_rf[32];
  logic [W-1:0] dut_rf[32];
  int           nvec, nerr, cyc;
  bit           chk;
  logic         exp_ready, exp_init;
  logic [3:0]   exp_busy;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic bit queued(input logic [4:0] a);
    queued = 1'b0;
    if (a[0]) begin
      foreach (mq1[i]) if (mq1[i].a == a) queued = 1'b1;
    end else begin
      foreach (mq0[i]) if (mq0[i].a == a) queued = 1'b1;
    end
  endfunction

  function automatic void model_push(input logic [4:0] a, input logic [W-1:0] d);
    ent_t e;
    e.a = a;
    e.d = d;
    if (a[0]) mq1.push_back(e);
    else      mq0.push_back(e);
  endfunction

  // One clock of stimulus; expectations use the model state at cycle start.
  task automatic step(input bit rst, input bit v0, input logic [4:0] a0, input logic [W-1:0] d0,
                      input bit v1, input logic [4:0] a1, input logic [W-1:0] d1,
                      input logic [3:0][4:0] ra);
    @(posedge clk);
    #1;
    rst_n       = rst;
    wb0_valid_i = v0; wb0_addr_i = a0; wb0_data_i = d0;
    wb1_valid_i = v1; wb1_addr_i = a1; wb1_data_i = d1;
    ra_i        = ra;
    if (!rst) begin
      mq0.delete();
      mq1.delete();
      cyc       = 0;
      exp_init  = 1'b1;
      exp_ready = 1'b0;
      exp_busy  = '0;
    end else begin
      exp_init  = (cyc < IC);
      exp_ready = !exp_init && (mq0.size() <= D - 2) && (mq1.size() <= D - 2);
      for (int k = 0; k < 4; k++) exp_busy[k] = (ra[k] != 5'd0) && queued(ra[k]);
      if (exp_ready) begin
        if (v0 && a0 != 5'd0) model_push(a0, d0);
        if (v1 && a1 != 5'd0) model_push(a1, d1);
      end
      cyc++;
    end
    chk = 1'b1;
  endtask

  task automatic idle(input int n, input logic [3:0][4:0] ra);
    for (int i = 0; i < n; i++) step(1, 0, 5'd0, '0, 0, 5'd0, '0, ra);
  endtask

  // Monitor: pops the expected write for each bank whenever one is due.
  always @(negedge clk) begin
    if (chk) begin
      ent_t e;
      check("wb_ready", W'(wb_ready_o), W'(exp_ready));
      check("init_busy", W'(init_busy_o), W'(exp_init));
      check("rd_busy", W'(rd_busy_o), W'(exp_busy));
      check("we0", W'(rf_we0_o), W'(mq0.size() > 0));
      if (mq0.size() > 0) begin
        e = mq0.pop_front();
        check("wa0", W'(rf_wa0_o), W'(e.a));
        check("wd0", rf_wd0_o, e.d);
        model_rf[e.a] = e.d;
      end else begin
        check("wa0_idle", W'(rf_wa0_o), '0);
        check("wd0_idle", rf_wd0_o, '0);
      end
      check("we1", W'(rf_we1_o), W'(mq1.size() > 0));
      if (mq1.size() > 0) begin
        e = mq1.pop_front();
        check("wa1", W'(rf_wa1_o), W'(e.a));
        check("wd1", rf_wd1_o, e.d);
        model_rf[e.a] = e.d;
      end else begin
        check("wa1_idle", W'(rf_wa1_o), '0);
        check("wd1_idle", rf_wd1_o, '0);
      end
      if (rf_we0_o) dut_rf[rf_wa0_o] = rf_wd0_o;
      if (rf_we1_o) dut_rf[rf_wa1_o] = rf_wd1_o;
    end
  end

  initial begin
    logic [3:0][4:0] ra;
    nvec = 0; nerr = 0; cyc = 0; chk = 1'b0;
    exp_ready = 1'b0; exp_init = 1'b1; exp_busy = '0;
    rst_n = 1'b0;
    wb0_valid_i = 1'b0; wb0_addr_i = '0; wb0_data_i = '0;
    wb1_valid_i = 1'b0; wb1_addr_i = '0; wb1_data_i = '0;
    ra_i = '0;
    for (int r = 0; r < 32; r++) begin
      model_rf[r] = '0;
      dut_rf[r]   = '0;
    end

    // Reset, then the init window (ready must rise on the 17th cycle).
    for (int i = 0; i < 3; i++) step(0, 0, 5'd0, '0, 0, 5'd0, '0, '0);
    idle(IC + 2, '0);

    // Different banks, both empty: same-cycle writes, nothing queued.
    step(1, 1, 5'd2, 32'hA, 1, 5'd3, 32'hB, {5'd3, 5'd2, 5'd3, 5'd2});
    idle(1, '0);

    // Bank-0 collision; ra[0]=6 shows busy while r6 waits its turn.
    step(1, 1, 5'd4, 32'h1, 1, 5'd6, 32'h2, {5'd0, 5'd0, 5'd0, 5'd6});
    idle(2, {5'd0, 5'd0, 5'd0, 5'd6});

    // Same address twice: 0x11 then 0x22.
    step(1, 1, 5'd5, 32'h11, 1, 5'd5, 32'h22, {5'd0, 5'd0, 5'd5, 5'd0});
    idle(2, {5'd0, 5'd0, 5'd5, 5'd0});

    // r0 requests are swallowed.
    step(1, 1, 5'd0, 32'hFF, 1, 5'd0, 32'hEE, '0);
    idle(1, '0);

    // Stream even pairs until ready backs off, then drain.
    for (int i = 0; i < 8; i++)
      step(1, 1, 5'(2 * $urandom_range(1, 15)), $urandom, 1, 5'(2 * $urandom_range(1, 15)),
           $urandom, {5'd8, 5'd6, 5'd4, 5'd2});
    idle(6, '0);

    // Reset with three entries queued in bank 0.
    for (int i = 0; i < 3; i++)
      step(1, 1, 5'(2 * i + 10), $urandom, 1, 5'(2 * i + 20), $urandom, '0);
    step(0, 0, 5'd0, '0, 0, 5'd0, '0, {5'd0, 5'd0, 5'd0, 5'd10});
    idle(IC + 4, {5'd24, 5'd20, 5'd12, 5'd10});

    // Random traffic with small address range to force collisions and hazards.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++) ra[k] = 5'($urandom_range(0, 11));
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 11)), $urandom,
           ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 11)), $urandom, ra);
    end
    idle(IC + 8, '0);

    @(negedge clk);
    #1;
    chk = 1'b0;
    for (int r = 1; r < 32; r++) check($sformatf("rf_r%0d", r), dut_rf[r], model_rf[r]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
